// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter
// Shares one single-ported memory between the core and the loader/debug port,
// one transaction at a time. Define ARB_ROUND_ROBIN_EN for round-robin ties;
// otherwise the loader has fixed priority.
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_done,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_l_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_any_req;
    logic              w_pick_loader;
    logic              w_last_wait;

    assign w_any_req   = c_req | l_req;
    assign w_last_wait = (r_state == S_WAIT) && (r_cnt == '0);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_loader;

    // On a tie, the requester that was not served last wins.
    assign w_pick_loader = l_req & (~c_req | ~r_last_loader);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_loader <= 1'b1;
        end else if (w_last_wait) begin
            r_last_loader <= r_owner;
        end
    end
`else
    assign w_pick_loader = l_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_next = S_ACCESS;
            S_ACCESS: w_state_next = S_WAIT;
            S_WAIT:   if (r_cnt == '0) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_c_rdata <= '0;
            r_l_rdata <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_pick_loader;
                        r_we    <= w_pick_loader ? l_we    : c_we;
                        r_addr  <= w_pick_loader ? l_addr  : c_addr;
                        r_wdata <= w_pick_loader ? l_wdata : c_wdata;
                    end
                end
                S_ACCESS: r_cnt <= CNT_W'(MEM_LATENCY - 1);
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        // Writes leave the requester's read data untouched.
                        if (!r_we) begin
                            if (r_owner) begin
                                r_l_rdata <= mem_rdata;
                            end else begin
                                r_c_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign c_gnt     = busy & ~r_owner;
    assign l_gnt     = busy & r_owner;
    assign c_done    = (r_state == S_DONE) & ~r_owner;
    assign l_done    = (r_state == S_DONE) & r_owner;
    assign mem_en    = (r_state == S_ACCESS);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign c_rdata   = r_c_rdata;
    assign l_rdata   = r_l_rdata;
    assign owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter
// Self-checking bench for mem_arbiter; instance 0 uses latency 2, instance 1
// latency 1, instance 2 latency 8, all sharing the same stimulus.
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int L0 = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, l_addr = '0, l_wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic        c_gnt [3], c_done [3], l_gnt [3], l_done [3];
    logic        mem_en [3], mem_we [3], busy [3], owner [3];
    logic [31:0] c_rdata [3], l_rdata [3], mem_addr [3], mem_wdata [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
            mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) u_dut (
                .clk(clk), .rst(rst),
                .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
                .c_gnt(c_gnt[g]), .c_done(c_done[g]), .c_rdata(c_rdata[g]),
                .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
                .l_gnt(l_gnt[g]), .l_done(l_done[g]), .l_rdata(l_rdata[g]),
                .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
                .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata),
                .busy(busy[g]), .owner(owner[g])
            );
        end
    endgenerate

    typedef struct {
        logic        who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memval;
        logic [31:0] exp_c;
        logic [31:0] exp_l;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {c_gnt, l_gnt, c_done, l_done, mem_en, mem_we, busy, owner}
    function automatic logic [7:0] ctrl(input int g);
        return {c_gnt[g], l_gnt[g], c_done[g], l_done[g], mem_en[g], mem_we[g], busy[g], owner[g]};
    endfunction

    task automatic drive(input logic who, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (who) begin
            l_req = req; l_we = we; l_addr = a; l_wdata = d;
        end else begin
            c_req = req; c_we = we; c_addr = a; c_wdata = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        rst = 1'b0;
    endtask

    // Single isolated transaction on instance 0; requester fields are scrambled after the grant.
    task automatic run_vec(input int id, input vec_t v);
        logic [7:0] e;
        drive(v.who, 1'b1, v.we, v.addr, v.wdata);
        mem_rdata = $urandom;
        for (int k = 1; k <= L0 + 2; k++) begin
            step();
            e = {!v.who, v.who, (k == L0 + 2) && !v.who, (k == L0 + 2) && v.who,
                 k == 1, v.we, 1'b1, v.who};
            chk($sformatf("vec%0d ctrl cyc%0d", id, k), {24'h0, ctrl(0)}, {24'h0, e});
            chk($sformatf("vec%0d mem_addr cyc%0d", id, k), mem_addr[0], v.addr);
            chk($sformatf("vec%0d mem_wdata cyc%0d", id, k), mem_wdata[0], v.wdata);
            if (k == L0 + 2) begin
                chk($sformatf("vec%0d c_rdata at done", id), c_rdata[0], v.exp_c);
                chk($sformatf("vec%0d l_rdata at done", id), l_rdata[0], v.exp_l);
                drive(v.who, 1'b0, 1'b0, 32'h0, 32'h0);
            end else begin
                drive(v.who, 1'b1, 1'($urandom % 2), $urandom, $urandom);
            end
            mem_rdata = (k == L0 + 1) ? v.memval : $urandom;
        end
        step();
        chk($sformatf("vec%0d idle ctrl", id), {24'h0, ctrl(0)}, {24'h0, 5'b0, v.we, 1'b0, v.who});
        chk($sformatf("vec%0d c_rdata held", id), c_rdata[0], v.exp_c);
        chk($sformatf("vec%0d l_rdata held", id), l_rdata[0], v.exp_l);
    endtask

    task automatic maybe_req(input logic who, input int prob);
        if ($urandom % prob == 0) begin
            drive(who, 1'b1, 1'($urandom % 2), $urandom, $urandom);
        end else begin
            drive(who, 1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    // Randomised requesters on instance 0 against a cycle-position model of one transaction.
    task automatic random_run(input int ncyc);
        int          pos;
        logic        mown, mwe, last_l, win, act, rq;
        logic [31:0] maddr, mwd, mrc, mrl;
        logic [7:0]  e;
        do_reset();
        pos = -1; mown = 1'b0; mwe = 1'b0; last_l = 1'b1;
        maddr = '0; mwd = '0; mrc = '0; mrl = '0;
        for (int n = 0; n < ncyc; n++) begin
            for (int w = 0; w < 2; w++) begin
                act = (pos >= 1) && (mown == w[0]);
                rq  = w[0] ? l_req : c_req;
                if (act && pos == L0 + 2) begin
                    maybe_req(w[0], 2);
                end else if (act) begin
                    drive(w[0], ($urandom % 8) != 0, 1'($urandom % 2), $urandom, $urandom);
                end else if (!rq) begin
                    maybe_req(w[0], 3);
                end
            end
            mem_rdata = $urandom;
            if (pos == -1) begin
                if (c_req || l_req) begin
                    if (c_req && l_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                        win = !last_l;
`else
                        win = 1'b1;
`endif
                    end else begin
                        win = l_req;
                    end
                    mown  = win;
                    mwe   = win ? l_we : c_we;
                    maddr = win ? l_addr : c_addr;
                    mwd   = win ? l_wdata : c_wdata;
                    pos   = 1;
                end
            end else if (pos == L0 + 1) begin
                if (!mwe) begin
                    if (mown) mrl = mem_rdata;
                    else      mrc = mem_rdata;
                end
                last_l = mown;
                pos++;
            end else if (pos == L0 + 2) begin
                pos = -1;
            end else begin
                pos++;
            end
            step();
            e = {pos > 0 && !mown, pos > 0 && mown, pos == L0 + 2 && !mown,
                 pos == L0 + 2 && mown, pos == 1, mwe, pos > 0, mown};
            chk($sformatf("rand ctrl n%0d", n), {24'h0, ctrl(0)}, {24'h0, e});
            chk($sformatf("rand mem_addr n%0d", n), mem_addr[0], maddr);
            chk($sformatf("rand mem_wdata n%0d", n), mem_wdata[0], mwd);
            chk($sformatf("rand c_rdata n%0d", n), c_rdata[0], mrc);
            chk($sformatf("rand l_rdata n%0d", n), l_rdata[0], mrl);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int          seen, cyc, dn, dcyc;
        logic        exp_own, addr_ok;
        logic [31:0] en_m, dn_m, bz_m;

        tbl[0] = '{1'b0, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 32'h20,       32'h12345678, 32'hAAAA5555, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h24,       32'h0,        32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D};
        tbl[3] = '{1'b0, 1'b1, 32'h30,       32'h0BADF00D, 32'h11111111, 32'hDEADBEEF, 32'hCAFEF00D};
        tbl[4] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h00000000, 32'h0,        32'hCAFEF00D};
        tbl[5] = '{1'b1, 1'b1, 32'h0,        32'hFFFFFFFF, 32'h77777777, 32'h0,        32'hCAFEF00D};
        tbl[6] = '{1'b1, 1'b0, 32'hABC,      32'h0,        32'h13579BDF, 32'h0,        32'h13579BDF};

        rst = 1'b1;
        step();
        step();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset ctrl i%0d", g), {24'h0, ctrl(g)}, 32'h0);
            chk($sformatf("reset c_rdata i%0d", g), c_rdata[g], 32'h0);
            chk($sformatf("reset l_rdata i%0d", g), l_rdata[g], 32'h0);
            chk($sformatf("reset mem_addr i%0d", g), mem_addr[g], 32'h0);
            chk($sformatf("reset mem_wdata i%0d", g), mem_wdata[g], 32'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

        // Both requesters hold req continuously on the latency-1 instance.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        seen = 0;
        cyc = 0;
        while (seen < 4 && cyc < 40) begin
            step();
            cyc++;
            if (mem_en[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_own = seen[0];
`else
                exp_own = 1'b1;
`endif
                chk($sformatf("arb owner t%0d", seen), 32'(owner[1]), 32'(exp_own));
                chk($sformatf("arb addr t%0d", seen), mem_addr[1], exp_own ? 32'h200 : 32'h100);
                chk($sformatf("arb grant cycle t%0d", seen), 32'(cyc), 32'(1 + 4 * seen));
                seen++;
            end
        end
        if (seen < 4) begin
            checks++;
            errors++;
            $display("FAIL arb timeout: got %0d grants, expected 4", seen);
        end

        // Reset during WAIT of a core read drops the transaction.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        step();
        step();
        chk("rstwait pre ctrl", {24'h0, ctrl(0)}, {24'h0, 8'b1000_0010});
        rst = 1'b1;
        c_req = 1'b0;
        step();
        rst = 1'b0;
        chk("rstwait ctrl", {24'h0, ctrl(0)}, 32'h0);
        chk("rstwait mem_addr", mem_addr[0], 32'h0);
        chk("rstwait l_rdata", l_rdata[0], 32'h0);
        dn = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (c_done[0] || busy[0]) dn++;
        end
        chk("rstwait no done", 32'(dn), 32'h0);
        run_vec(7, '{1'b0, 1'b0, 32'h50, 32'h0, 32'h5A5AA5A5, 32'h5A5AA5A5, 32'h0});

        // Address change during grant and req dropped in WAIT.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        dn = 0;
        dcyc = 0;
        addr_ok = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (c_done[0]) begin
                dn++;
                dcyc = k;
            end
            if (mem_addr[0] !== 32'h10) addr_ok = 1'b0;
            if (k == 1) c_addr = 32'h40;
            if (k == 2) c_req = 1'b0;
        end
        chk("drop done count", 32'(dn), 32'h1);
        chk("drop done cycle", 32'(dcyc), 32'h4);
        chk("drop mem_addr held", 32'(addr_ok), 32'h1);
        chk("drop idle busy", 32'(busy[0]), 32'h0);

        // Latency-8 instance single read.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h80, 32'h0);
        mem_rdata = $urandom;
        en_m = '0;
        dn_m = '0;
        bz_m = '0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (mem_en[2]) en_m |= 32'h1 << k;
            if (c_done[2]) begin
                dn_m |= 32'h1 << k;
                c_req = 1'b0;
            end
            if (busy[2]) bz_m |= 32'h1 << k;
            if (k == 10) chk("lat8 c_rdata", c_rdata[2], 32'h88880001);
            mem_rdata = (k == 9) ? 32'h88880001 : $urandom;
        end
        chk("lat8 mem_en cycles", en_m, 32'h2);
        chk("lat8 done cycles", dn_m, 32'h400);
        chk("lat8 busy cycles", bz_m, 32'h7FE);

        random_run(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
